imem_bridge: RTL and testbench

IMEM_BRIDGE -- requirements
Module: imem_bridge

---
 rtl/imem_bridge_if.sv | 24 ++
 rtl/imem_bridge.sv | 143 ++++++++++++++
 tb/tb_imem_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_bridge_if.sv
// Memory-side bus of the instruction fetch bridge.
//
// Handshake: the master raises req with addr and holds both stable until the
// slave answers with gnt in the same cycle; the request is accepted on that
// edge. After acceptance the slave returns exactly one rvalid pulse carrying
// rdata. No new request is issued until that read data (or a fetch timeout)
// closes the transaction.
//
// Signals
//   req     master -> slave  request valid (mem_req_o)
//   addr    master -> slave  word-aligned byte address (mem_addr_o)
//   gnt     slave -> master  request accepted (mem_gnt_i)
//   rvalid  slave -> master  read data valid (mem_rvalid_i)
//   rdata   slave -> master  read data (mem_rdata_i)
interface imem_bridge_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/imem_bridge.sv
// Instruction fetch bridge: serves core fetches from a one-entry instruction
// buffer and refills it over a req/gnt/rvalid memory bus on a miss.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   rom_ce_i    core fetch enable
//   rom_addr_i  core fetch byte address (low two bits ignored)
//   rom_data_o  instruction word, valid when stallreq_o is low and rom_ce_i high
//   stallreq_o  stall request to the pipeline controller
//   flush_i     invalidate the buffered instruction
//   mem         memory bus (master side)
//   err_o       sticky fetch-timeout flag
//   dbg_state   current FSM state (0 idle, 1 request, 2 wait for data)
module imem_bridge #(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rom_ce_i,
  input  logic [31:0]        rom_addr_i,
  output logic [31:0]        rom_data_o,
  output logic               stallreq_o,
  input  logic               flush_i,
  imem_bridge_if.master      mem,
  output logic               err_o,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    state;
  logic [29:0]   req_addr;
  logic [CW-1:0] cnt;
  logic          buf_valid;
  logic [29:0]   buf_addr;
  logic [31:0]   buf_data;
  // Set when a flush lands while a fetch is outstanding: the fetch still
  // finishes on the bus but its data must not become visible.
  logic          drop;

  logic          hit;
  logic          busy;
  logic          timeout;
  logic          rdata_take;
  logic          fill;
  logic [31:0]   fill_data;

  // Byte offset within the word has no effect on which instruction is fetched.
  logic          unused_addr_lsb;
  assign unused_addr_lsb = ^rom_addr_i[1:0];

  assign busy       = (state != S_IDLE);
  assign hit        = (state == S_IDLE) && rom_ce_i && buf_valid &&
                      (buf_addr == rom_addr_i[31:2]);
  assign rdata_take = (state == S_WAIT) && mem.rvalid;
  // The counter starts at 0 in the first REQ cycle, so TIMEOUT_CYC cycles in
  // REQ/WAIT have elapsed when it reads TIMEOUT_CYC-1. Read data arriving in
  // that same cycle counts as completion, not timeout.
  assign timeout    = busy && !rdata_take && (cnt == CW'(TIMEOUT_CYC - 1));
  assign fill       = rdata_take || timeout;
  assign fill_data  = rdata_take ? mem.rdata : NOP_INST;

  assign rom_data_o = hit ? buf_data : 32'h0;
  // Gated by rst so the stall is low while reset is held even if ce is high.
  assign stallreq_o = rst && (busy || (rom_ce_i && !hit));
  assign mem.req    = (state == S_REQ);
  assign mem.addr   = {req_addr, 2'b00};
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      req_addr <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rom_ce_i && !hit) begin
            req_addr <= rom_addr_i[31:2];
            cnt      <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (timeout) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (mem.gnt) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fill) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= 1'b0;
    end else if (state == S_IDLE) begin
      drop <= 1'b0;
    end else if (flush_i) begin
      drop <= 1'b1;
    end
  end

  // Flush wins over a same-cycle fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (flush_i) begin
      buf_valid <= 1'b0;
    end else if (fill && !drop) begin
      buf_valid <= 1'b1;
      buf_addr  <= req_addr;
      buf_data  <= fill_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if (timeout) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_bridge.sv
module tb_imem_bridge;
  localparam int          TO  = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = '0;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush = 1'b0;
  logic        err;
  logic [1:0]  dbg_state;

  imem_bridge_if mem_if ();

  imem_bridge #(.TIMEOUT_CYC(TO), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data),
    .stallreq_o (stall),
    .flush_i    (flush),
    .mem        (mem_if),
    .err_o      (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit required summary reached");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  // reference model: buffer contents and error flag at fetch granularity
  logic        m_valid = 1'b0;
  logic [29:0] m_addr  = '0;
  logic [31:0] m_data  = '0;
  logic        m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h40) return 32'h00500093;
    return {a[31:2], 2'b00} * 32'h9E3779B1 + 32'h1357;
  endfunction

  // One core fetch of address a. gd: cycles the memory withholds gnt,
  // rd: cycles after grant before rvalid. fmode=1 raises flush together
  // with the first rvalid. Called and returns at posedge+1.
  task automatic do_fetch(input logic [31:0] a, input int gd, input int rd, input bit fmode);
    int          exp_stalls;
    int          exp_reqs;
    int          stalls;
    int          reqs;
    int          ph;
    int          c;
    int          txn;
    int          cg;
    int          cr;
    bit          done;
    bit          to;
    logic        prev_req;
    logic [31:0] exp_data;
    logic [31:0] got_exp;

    if (m_valid && m_addr == a[31:2]) begin
      exp_stalls = 0;
      exp_reqs   = 0;
      exp_data   = m_data;
    end else if (fmode) begin
      exp_stalls = gd + rd + 6;
      exp_reqs   = 2;
      exp_data   = mem_word(a);
      m_valid = 1'b1; m_addr = a[31:2]; m_data = exp_data;
    end else begin
      to         = (gd + rd + 2 > TO);
      exp_stalls = to ? TO + 1 : gd + rd + 3;
      exp_reqs   = 1;
      exp_data   = to ? NOP : mem_word(a);
      m_err      = m_err | to;
      m_valid = 1'b1; m_addr = a[31:2]; m_data = exp_data;
    end
    exp_q.push_back(exp_data);

    rom_ce = 1'b1;
    rom_addr = a;
    stalls = 0; reqs = 0; ph = 0; c = 0; txn = 0; cg = gd; cr = rd;
    done = 1'b0; prev_req = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall) begin
        got_exp = exp_q.pop_front();
        check("rom_data", rom_data, got_exp);
        check("stall_cycles", stalls, exp_stalls);
        check("req_count", reqs, exp_reqs);
        check("hit_no_req", {31'h0, mem_if.req}, 32'h0);
        check("err", {31'h0, err}, {31'h0, m_err});
        done = 1'b1;
      end else begin
        stalls++;
        if (rom_data !== 32'h0) check("data_while_stall", rom_data, 32'h0);
        if (mem_if.req) begin
          check("mem_addr", mem_if.addr, {a[31:2], 2'b00});
          if (!prev_req) reqs++;
        end
        if (ph == 0 && mem_if.req) begin
          if (c == cg) begin mem_if.gnt = 1'b1; ph = 1; c = 0; end
          else c++;
        end else if (ph == 1) begin
          if (c == cr) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = mem_word(a);
            flush = fmode && (txn == 0);
            ph = 0; c = 0; txn++; cg = 0; cr = 0;
          end else c++;
        end
      end
      prev_req = mem_if.req;
      @(posedge clk); #1;
      mem_if.gnt = 1'b0;
      mem_if.rvalid = 1'b0;
      mem_if.rdata = $urandom;
      flush = 1'b0;
    end
    check("fetch_done", {31'h0, done}, 32'h1);
  endtask

  // One cycle with fetch disabled, optionally flushing the buffer.
  task automatic idle_cycle(input bit f);
    rom_ce = 1'b0;
    rom_addr = $urandom;
    flush = f;
    @(negedge clk);
    check("ce0_data", rom_data, 32'h0);
    check("ce0_stall", {31'h0, stall}, 32'h0);
    check("ce0_req", {31'h0, mem_if.req}, 32'h0);
    if (f) m_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    mem_if.gnt = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata = '0;
    rom_ce = 1'b1;
    rom_addr = 32'h100;

    // reset state, with ce held high
    #12;
    check("rst_data", rom_data, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_req", {31'h0, mem_if.req}, 32'h0);
    check("rst_addr", mem_if.addr, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // cold fetch, then hit on a different byte of the same word
    do_fetch(32'h100, 0, 0, 0);
    do_fetch(32'h102, 0, 0, 0);
    // flush, then refetch with a delayed grant
    idle_cycle(1'b1);
    do_fetch(32'h100, 4, 0, 0);
    // boundary: completion in the last allowed cycle, then a real timeout
    do_fetch(32'h200, 3, 3, 0);
    do_fetch(32'h300, 0, 10, 0);
    idle_cycle(1'b0);
    check("err_sticky", {31'h0, err}, 32'h1);
    do_fetch(32'h301, 0, 0, 0);
    // flush coincident with rvalid forces a second request
    do_fetch(32'h400, 1, 2, 1);

    // reset while waiting for read data
    rom_ce = 1'b1;
    rom_addr = 32'h500;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    mem_if.gnt = 1'b1;
    @(posedge clk); #1;
    mem_if.gnt = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_req", {31'h0, mem_if.req}, 32'h0);
    check("midrst_addr", mem_if.addr, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_data", rom_data, 32'h0);
    check("midrst_err", {31'h0, err}, 32'h0);
    check("midrst_state", {30'h0, dbg_state}, 32'h0);
    m_valid = 1'b0;
    m_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rom_ce = 1'b0;
    mem_if.rvalid = 1'b1;
    mem_if.rdata = mem_word(32'h500);
    @(negedge clk);
    check("late_rvalid_req", {31'h0, mem_if.req}, 32'h0);
    check("late_rvalid_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    mem_if.rvalid = 1'b0;
    do_fetch(32'h500, 0, 0, 0);

    // randomized traffic over a small address pool
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) idle_cycle(1'($urandom_range(0, 1)));
      a = 32'h1000 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
      if (sel == 9) do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      else          do_fetch(a, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
